// File: rtl/mc_mem_pkg.sv
// mc_mem_pkg
// Shared definitions for the multi-channel data memory:
//   - default data and address widths
//   - ch_idx_w(): bits needed to index NUM_CH channels (never less than 1)
//   - pack_offset(): first bit of channel k in a packed per-channel bus
//   - acc_kind_e: the kind of access selected for the current cycle
package mc_mem_pkg;

  localparam int DEF_DATA_W = 64;
  localparam int DEF_ADDR_W = 8;

  typedef enum logic {
    ACC_READ  = 1'b0,
    ACC_WRITE = 1'b1
  } acc_kind_e;

  // Smallest w with 2**w >= num_ch; a single channel still gets a 1-bit index.
  function automatic int ch_idx_w(input int num_ch);
    int w;
    w = 1;
    while ((1 << w) < num_ch) w++;
    return w;
  endfunction

  // Channel k of a packed bus starts at bit k*width (ascending bit order).
  function automatic int pack_offset(input int ch, input int width);
    return ch * width;
  endfunction

endpackage

// File: rtl/mc_dmem_arb_rr_arbiter.sv
// rr_arbiter
// Round-robin arbiter with a rotating start pointer.
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   asynchronous active-low reset (pointer -> 0, gnt forced 0)
//   advance  in   the granted access is accepted this cycle; pointer may move
//   req      in   NUM_CH request lines
//   gnt      out  NUM_CH one-hot grant, combinational
module rr_arbiter
  import mc_mem_pkg::*;
#(
  parameter int NUM_CH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              advance,
  input  logic [NUM_CH-1:0] req,
  output logic [NUM_CH-1:0] gnt
);

  localparam int IDX_W = ch_idx_w(NUM_CH);

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] cand_idx;
  logic             found;

  // Search pointer, pointer+1, ... modulo NUM_CH; the first requester wins.
  always_comb begin
    gnt      = '0;
    win_idx  = '0;
    cand_idx = '0;
    found    = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      cand_idx = IDX_W'((int'(ptr_q) + i) % NUM_CH);
      if (!found && req[cand_idx]) begin
        found   = 1'b1;
        win_idx = cand_idx;
      end
    end
    if (found && reset) begin
      gnt[win_idx] = 1'b1;
    end
  end

  // The winner becomes lowest priority next cycle; no grant leaves it alone.
  always_comb begin
    ptr_d = ptr_q;
    if (advance && found && reset) begin
      if (int'(win_idx) == NUM_CH - 1) begin
        ptr_d = '0;
      end else begin
        ptr_d = win_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/mc_dmem_arb.sv
// mc_dmem_arb
// Multi-channel single-port data memory. NUM_CH requesters share one
// synchronous RAM through a round-robin arbiter; one access per cycle.
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-low reset (MEM is not cleared)
//   ch_req     in   per-channel request, held until granted
//   ch_wr_en   in   per-channel write(1)/read(0)
//   ch_addr    in   packed word addresses, channel k at [k*ADDR_W +: ADDR_W]
//   ch_wdata   in   packed write data, channel k at [k*DATA_W +: DATA_W]
//   ch_gnt     out  one-hot grant, combinational in the request cycle
//   ch_rvalid  out  one-hot read-data valid, one cycle after a read grant
//   rdata      out  shared read data bus, bit 0 is the MSB
module mc_dmem_arb
  import mc_mem_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        ch_req,
  input  logic [NUM_CH-1:0]        ch_wr_en,
  input  logic [0:NUM_CH*ADDR_W-1] ch_addr,
  input  logic [0:NUM_CH*DATA_W-1] ch_wdata,
  output logic [NUM_CH-1:0]        ch_gnt,
  output logic [NUM_CH-1:0]        ch_rvalid,
  output logic [0:DATA_W-1]        rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [0:DATA_W-1] MEM [0:DEPTH-1];

  logic [0:ADDR_W-1] sel_addr;
  logic [0:DATA_W-1] sel_wdata;
  acc_kind_e         sel_kind;
  logic              any_gnt;

  logic [0:DATA_W-1] rdata_q;
  logic [0:DATA_W-1] rdata_d;
  logic [NUM_CH-1:0] rvalid_q;
  logic [NUM_CH-1:0] rvalid_d;

  rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_arb (
    .clk     (clk),
    .reset   (reset),
    .advance (|ch_req),
    .req     (ch_req),
    .gnt     (ch_gnt)
  );

  // Steer the granted channel's address, data and direction onto the RAM.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_kind  = ACC_READ;
    any_gnt   = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ch_gnt[k]) begin
        any_gnt   = 1'b1;
        sel_addr  = ch_addr[pack_offset(k, ADDR_W) +: ADDR_W];
        sel_wdata = ch_wdata[pack_offset(k, DATA_W) +: DATA_W];
        sel_kind  = ch_wr_en[k] ? ACC_WRITE : ACC_READ;
      end
    end
  end

  // A granted read loads the data register and flags the winner; any other
  // cycle drops rvalid and leaves the last read data on the bus.
  always_comb begin
    rdata_d  = rdata_q;
    rvalid_d = '0;
    if (any_gnt && sel_kind == ACC_READ) begin
      rdata_d  = MEM[sel_addr];
      rvalid_d = ch_gnt;
    end
  end

  // Storage has no reset so preloaded contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (any_gnt && sel_kind == ACC_WRITE) begin
      MEM[sel_addr] <= sel_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_q  <= '0;
      rvalid_q <= '0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign rdata     = rdata_q;
  assign ch_rvalid = rvalid_q;

endmodule

// File: tb/tb_mc_dmem_arb.sv
// tb_mc_dmem_arb
// Randomised and directed stimulus for mc_dmem_arb, compared against a
// behavioural model (word array + rotating priority pointer).
module tb_mc_dmem_arb;

  localparam int NCH = 4;
  localparam int AW  = 8;
  localparam int DW  = 64;

  logic              clk;
  logic              reset;
  logic [NCH-1:0]    ch_req;
  logic [NCH-1:0]    ch_wr_en;
  logic [0:NCH*AW-1] ch_addr;
  logic [0:NCH*DW-1] ch_wdata;
  logic [NCH-1:0]    ch_gnt;
  logic [NCH-1:0]    ch_rvalid;
  logic [0:DW-1]     rdata;

  mc_dmem_arb #(.NUM_CH(NCH), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .ch_req    (ch_req),
    .ch_wr_en  (ch_wr_en),
    .ch_addr   (ch_addr),
    .ch_wdata  (ch_wdata),
    .ch_gnt    (ch_gnt),
    .ch_rvalid (ch_rvalid),
    .rdata     (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  // per-channel requester state
  logic [NCH-1:0] t_req;
  logic [NCH-1:0] t_wr;
  logic [AW-1:0]  t_addr  [NCH];
  logic [DW-1:0]  t_wdata [NCH];

  // reference model
  logic [DW-1:0]  m_mem [256];
  int             m_ptr;
  int             m_g;
  logic [NCH-1:0] exp_gnt;
  logic [NCH-1:0] exp_rvalid;
  logic [DW-1:0]  exp_rdata;

  function automatic int pick(input logic [NCH-1:0] r);
    if (!reset) return -1;
    for (int i = 0; i < NCH; i++) begin
      if (r[(m_ptr + i) % NCH]) return (m_ptr + i) % NCH;
    end
    return -1;
  endfunction

  // Put the requester state on the pins and predict this cycle's grant.
  task automatic apply_inputs();
    ch_req   = t_req;
    ch_wr_en = t_wr;
    for (int k = 0; k < NCH; k++) begin
      ch_addr[k*AW +: AW]  = t_addr[k];
      ch_wdata[k*DW +: DW] = t_wdata[k];
    end
    m_g     = pick(t_req);
    exp_gnt = (m_g >= 0) ? NCH'(1 << m_g) : '0;
    #1;
  endtask

  // Clock edge: advance the model, then settle past the edge.
  task automatic tick();
    @(posedge clk);
    if (!reset) begin
      m_ptr      = 0;
      exp_rvalid = '0;
      exp_rdata  = '0;
    end else if (m_g >= 0) begin
      if (t_wr[m_g]) begin
        m_mem[t_addr[m_g]] = t_wdata[m_g];
        exp_rvalid = '0;
      end else begin
        exp_rvalid = NCH'(1 << m_g);
        exp_rdata  = m_mem[t_addr[m_g]];
      end
      m_ptr = (m_g + 1) % NCH;
    end else begin
      exp_rvalid = '0;
    end
    #1;
  endtask

  task automatic clear_reqs();
    t_req = '0;
    t_wr  = '0;
    for (int k = 0; k < NCH; k++) begin
      t_addr[k]  = '0;
      t_wdata[k] = '0;
    end
  endtask

  task automatic test_reset();
    clear_reqs();
    t_req = 4'b1111;
    t_wr  = 4'b1111;
    for (int k = 0; k < NCH; k++) begin
      t_addr[k]  = AW'(k);
      t_wdata[k] = {$urandom, $urandom};
    end
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      apply_inputs();
      n_checks++;
      if (ch_gnt !== 4'b0000) begin
        n_fails++;
        $display("[TB] FAIL reset_gnt cycle %0d: got %b want 0000", c, ch_gnt);
      end
      tick();
      n_checks++;
      if (ch_rvalid !== 4'b0000 || rdata !== 64'h0) begin
        n_fails++;
        $display("[TB] FAIL reset_out cycle %0d: rvalid %b rdata %h want 0000/0", c, ch_rvalid, rdata);
      end
    end
    reset = 1'b1;
    apply_inputs();
    n_checks++;
    if (ch_gnt !== 4'b0001 || ch_gnt !== exp_gnt) begin
      n_fails++;
      $display("[TB] FAIL reset_first_gnt: got %b want 0001", ch_gnt);
    end
    tick();
    clear_reqs();
  endtask

  task automatic test_fill();
    for (int a = 0; a < 256; a++) begin
      clear_reqs();
      t_req[a % NCH]   = 1'b1;
      t_wr[a % NCH]    = 1'b1;
      t_addr[a % NCH]  = AW'(a);
      t_wdata[a % NCH] = {$urandom, $urandom};
      apply_inputs();
      n_checks++;
      if (ch_gnt !== exp_gnt) begin
        n_fails++;
        $display("[TB] FAIL fill_gnt addr %0d: got %b want %b", a, ch_gnt, exp_gnt);
      end
      tick();
      n_checks++;
      if (ch_rvalid !== 4'b0000) begin
        n_fails++;
        $display("[TB] FAIL fill_rvalid addr %0d: got %b want 0000", a, ch_rvalid);
      end
    end
    clear_reqs();
  endtask

  task automatic test_write_read();
    clear_reqs();
    t_req[1] = 1'b1; t_wr[1] = 1'b1;
    t_addr[1] = 8'h10; t_wdata[1] = 64'hDEADBEEF_01234567;
    apply_inputs();
    n_checks++;
    if (ch_gnt !== 4'b0010) begin
      n_fails++;
      $display("[TB] FAIL wr_gnt: got %b want 0010", ch_gnt);
    end
    tick();
    t_wr[1] = 1'b0;
    apply_inputs();
    tick();
    n_checks++;
    if (ch_rvalid !== 4'b0010 || rdata !== 64'hDEADBEEF_01234567) begin
      n_fails++;
      $display("[TB] FAIL wr_rd_data: rvalid %b rdata %h want 0010 deadbeef01234567", ch_rvalid, rdata);
    end
    clear_reqs();
    apply_inputs();
    tick();
    n_checks++;
    if (ch_rvalid !== 4'b0000 || rdata !== 64'hDEADBEEF_01234567) begin
      n_fails++;
      $display("[TB] FAIL rd_idle_hold: rvalid %b rdata %h want 0000 held", ch_rvalid, rdata);
    end
  endtask

  task automatic test_contention();
    logic [NCH-1:0] prev_gnt;
    // A lone ch3 grant parks the pointer at 0.
    clear_reqs();
    t_req[3] = 1'b1; t_addr[3] = AW'($urandom);
    apply_inputs();
    tick();
    for (int k = 0; k < NCH; k++) t_addr[k] = AW'($urandom);
    t_req = 4'b1111;
    prev_gnt = '0;
    for (int c = 0; c < 8; c++) begin
      apply_inputs();
      n_checks++;
      if (ch_gnt !== NCH'(1 << (c % NCH)) || ch_gnt !== exp_gnt) begin
        n_fails++;
        $display("[TB] FAIL contention_gnt cycle %0d: got %b want %b", c, ch_gnt, NCH'(1 << (c % NCH)));
      end
      prev_gnt = exp_gnt;
      tick();
      n_checks++;
      if (ch_rvalid !== prev_gnt || rdata !== exp_rdata) begin
        n_fails++;
        $display("[TB] FAIL contention_rd cycle %0d: rvalid %b rdata %h want %b %h", c, ch_rvalid, rdata, prev_gnt, exp_rdata);
      end
    end
    clear_reqs();
  endtask

  task automatic test_pointer_skip();
    clear_reqs();
    t_req[0] = 1'b1; t_addr[0] = AW'($urandom);
    apply_inputs();
    tick();
    t_req = 4'b1001; t_addr[3] = AW'($urandom);
    apply_inputs();
    n_checks++;
    if (ch_gnt !== 4'b1000) begin
      n_fails++;
      $display("[TB] FAIL skip_gnt_ch3: got %b want 1000", ch_gnt);
    end
    tick();
    apply_inputs();
    n_checks++;
    if (ch_gnt !== 4'b0001) begin
      n_fails++;
      $display("[TB] FAIL skip_gnt_ch0: got %b want 0001", ch_gnt);
    end
    tick();
    n_checks++;
    if (ch_rvalid !== 4'b0001 || rdata !== exp_rdata) begin
      n_fails++;
      $display("[TB] FAIL skip_rd: rvalid %b rdata %h want 0001 %h", ch_rvalid, rdata, exp_rdata);
    end
    clear_reqs();
  endtask

  task automatic test_read_after_write();
    clear_reqs();
    t_req[0] = 1'b1; t_wr[0] = 1'b1;
    t_addr[0] = 8'hFF; t_wdata[0] = 64'h0000_0000_0000_00AA;
    apply_inputs();
    tick();
    clear_reqs();
    t_req[2] = 1'b1; t_addr[2] = 8'hFF;
    apply_inputs();
    n_checks++;
    if (ch_gnt !== 4'b0100) begin
      n_fails++;
      $display("[TB] FAIL raw_gnt: got %b want 0100", ch_gnt);
    end
    tick();
    n_checks++;
    if (ch_rvalid !== 4'b0100 || rdata !== 64'h0000_0000_0000_00AA) begin
      n_fails++;
      $display("[TB] FAIL raw_data: rvalid %b rdata %h want 0100 00000000000000aa", ch_rvalid, rdata);
    end
    clear_reqs();
  endtask

  task automatic test_back_to_back();
    clear_reqs();
    t_req[2] = 1'b1;
    for (int c = 0; c < 8; c++) begin
      t_wr[2]    = 1'($urandom_range(0, 1));
      t_addr[2]  = AW'($urandom);
      t_wdata[2] = {$urandom, $urandom};
      apply_inputs();
      n_checks++;
      if (ch_gnt !== 4'b0100) begin
        n_fails++;
        $display("[TB] FAIL b2b_gnt cycle %0d: got %b want 0100", c, ch_gnt);
      end
      tick();
      n_checks++;
      if (ch_rvalid !== exp_rvalid || rdata !== exp_rdata) begin
        n_fails++;
        $display("[TB] FAIL b2b_out cycle %0d: rvalid %b rdata %h want %b %h", c, ch_rvalid, rdata, exp_rvalid, exp_rdata);
      end
    end
    clear_reqs();
  endtask

  task automatic test_random();
    clear_reqs();
    for (int c = 0; c < 300; c++) begin
      for (int k = 0; k < NCH; k++) begin
        if (!t_req[k]) begin
          if ($urandom_range(0, 1) == 1) begin
            t_req[k]   = 1'b1;
            t_wr[k]    = 1'($urandom_range(0, 1));
            t_addr[k]  = AW'($urandom);
            t_wdata[k] = {$urandom, $urandom};
          end
        end else if ($urandom_range(0, 15) == 0) begin
          t_req[k] = 1'b0;
        end
      end
      apply_inputs();
      n_checks++;
      if (ch_gnt !== exp_gnt) begin
        n_fails++;
        $display("[TB] FAIL rand_gnt cycle %0d: req %b got %b want %b", c, t_req, ch_gnt, exp_gnt);
      end
      tick();
      n_checks++;
      if (ch_rvalid !== exp_rvalid || rdata !== exp_rdata) begin
        n_fails++;
        $display("[TB] FAIL rand_out cycle %0d: rvalid %b rdata %h want %b %h", c, ch_rvalid, rdata, exp_rvalid, exp_rdata);
      end
      if (m_g >= 0) t_req[m_g] = 1'b0;
    end
    clear_reqs();
  endtask

  task automatic test_reset_mid_read();
    clear_reqs();
    t_req[1] = 1'b1; t_addr[1] = AW'($urandom);
    apply_inputs();
    n_checks++;
    if (ch_gnt !== 4'b0010) begin
      n_fails++;
      $display("[TB] FAIL midrst_pre_gnt: got %b want 0010", ch_gnt);
    end
    #1;
    reset = 1'b0;
    m_g   = -1;
    #1;
    n_checks++;
    if (ch_gnt !== 4'b0000) begin
      n_fails++;
      $display("[TB] FAIL midrst_gnt_forced: got %b want 0000", ch_gnt);
    end
    tick();
    n_checks++;
    if (ch_rvalid !== 4'b0000 || rdata !== 64'h0) begin
      n_fails++;
      $display("[TB] FAIL midrst_rvalid: rvalid %b rdata %h want 0000/0", ch_rvalid, rdata);
    end
    #1;
    reset = 1'b1;
    clear_reqs();
    for (int a = 0; a < 128; a++) begin
      t_req = 4'b0001;
      t_addr[0] = AW'(a);
      apply_inputs();
      tick();
      n_checks++;
      if (ch_rvalid !== 4'b0001 || rdata !== m_mem[a]) begin
        n_fails++;
        $display("[TB] FAIL dump addr %0d: rvalid %b rdata %h want 0001 %h", a, ch_rvalid, rdata, m_mem[a]);
      end
    end
    clear_reqs();
  endtask

  initial begin
    reset      = 1'b0;
    m_ptr      = 0;
    m_g        = -1;
    exp_gnt    = '0;
    exp_rvalid = '0;
    exp_rdata  = '0;
    for (int a = 0; a < 256; a++) m_mem[a] = '0;
    clear_reqs();
    ch_req   = '0;
    ch_wr_en = '0;
    ch_addr  = '0;
    ch_wdata = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_fill();
    test_write_read();
    test_contention();
    test_pointer_skip();
    test_read_after_write();
    test_back_to_back();
    test_random();
    test_reset_mid_read();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
